// File: rtl/rom_dl_sequencer.sv
// rtl/rom_dl_sequencer.sv - HPS ROM download sequencer: region decode, 4-deep FIFO, req/ack issue to ROM targets
// Holds the game core in reset until a complete, error-free image has drained to the targets.
module rom_dl_sequencer #(
  parameter logic [24:0] R1_BASE  = 25'h08000,
  parameter logic [24:0] R2_BASE  = 25'h0C000,
  parameter logic [24:0] R3_BASE  = 25'h10000,
  parameter logic [24:0] IMG_SIZE = 25'h14000,
  parameter int          AW       = 17,
  parameter int          RST_HOLD = 16
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          rom_req,
  input  logic          rom_ack,
  output logic [3:0]    rom_we,
  output logic [AW-1:0] rom_ad,
  output logic [7:0]    rom_dt,
  output logic          core_reset,
  output logic          dl_done,
  output logic          dl_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_HOLD, S_RUN, S_ERROR
  } state_t;

  localparam int EW = 2 + AW + 8;
  localparam int HW = $clog2(RST_HOLD) + 1;

  state_t          state, state_nx;
  logic            dl_q, dl_rise, dl_fall;
  logic [EW-1:0]   fifo_mem [4];
  logic [1:0]      rd_ptr, wr_ptr;
  logic [2:0]      occ, occ_nx;
  logic [24:0]     byte_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            err_q;
  logic            in_range;
  logic [1:0]      region;
  logic [24:0]     base;
  logic [AW-1:0]   rel_ad;
  logic            loading, push_try, push, pop, ovf, oor;
  logic [EW-1:0]   head;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  always_comb begin
    region = 2'd0;
    base   = '0;
    if (ioctl_addr < R1_BASE) begin
      region = 2'd0;
      base   = '0;
    end else if (ioctl_addr < R2_BASE) begin
      region = 2'd1;
      base   = R1_BASE;
    end else if (ioctl_addr < R3_BASE) begin
      region = 2'd2;
      base   = R2_BASE;
    end else begin
      region = 2'd3;
      base   = R3_BASE;
    end
  end

  assign in_range = (ioctl_addr < IMG_SIZE);
  assign rel_ad   = AW'(ioctl_addr - base);

  // Outputs are gated by rom_req so an empty FIFO never exposes stale entries.
  assign head    = fifo_mem[rd_ptr];
  assign rom_req = (occ != 3'd0);
  assign rom_we  = rom_req ? (4'b0001 << head[EW-1 -: 2]) : 4'b0000;
  assign rom_ad  = rom_req ? head[AW+7:8] : '0;
  assign rom_dt  = rom_req ? head[7:0] : 8'h00;

  assign pop      = rom_req & rom_ack;
  assign loading  = (state == S_LOAD);
  assign push_try = loading & ioctl_wr & in_range;
  assign push     = push_try & ((occ != 3'd4) | pop);
  assign ovf      = push_try & (occ == 3'd4) & ~pop;
  assign oor      = loading & ioctl_wr & ~in_range;
  assign occ_nx   = occ + {2'b00, push} - {2'b00, pop};

  assign core_reset = (state != S_RUN);
  assign dl_done    = (state == S_RUN);
  assign dl_error   = err_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (dl_fall) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (occ == 3'd0) begin
          if ((byte_cnt == IMG_SIZE) && !err_q) state_nx = S_HOLD;
          else                                  state_nx = S_ERROR;
        end
      end
      S_HOLD:  if (hold_cnt == HW'(RST_HOLD - 1)) state_nx = S_RUN;
      default: state_nx = state;
    endcase
    // A new download restarts from any state.
    if (dl_rise) state_nx = S_LOAD;
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= {region, rel_ad, ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      rd_ptr     <= 2'd0;
      wr_ptr     <= 2'd0;
      occ        <= 3'd0;
      byte_cnt   <= '0;
      hold_cnt   <= '0;
      err_q      <= 1'b0;
      ioctl_wait <= 1'b0;
    end else begin
      state    <= state_nx;
      dl_q     <= ioctl_download;
      hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
      if (dl_rise) begin
        rd_ptr     <= 2'd0;
        wr_ptr     <= 2'd0;
        occ        <= 3'd0;
        byte_cnt   <= '0;
        err_q      <= 1'b0;
        ioctl_wait <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 2'd1;
          if (byte_cnt != '1) byte_cnt <= byte_cnt + 25'd1;
        end
        if (pop) rd_ptr <= rd_ptr + 2'd1;
        occ        <= occ_nx;
        // Asserting at two leaves two free slots to absorb hps_io's wait latency.
        ioctl_wait <= (occ_nx >= 3'd2);
        if (ovf || oor || ((state == S_DRAIN) && (state_nx == S_ERROR))) err_q <= 1'b1;
      end
    end
  end

endmodule
